// File: rtl/sram_access_arbiter_pkg.sv
// sram_arb_pkg: shared widths, default read latency and arbiter state encoding.
package sram_arb_pkg;
    localparam int SRAM_ADDR_W  = 18;
    localparam int SRAM_DATA_W  = 16;
    localparam int DEF_READ_LAT = 2;
    typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_GRANT, S_ARB_SWITCH} arb_state_t;
endpackage

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester bus and SRAM_Controller port bundle for the arbiter.
interface sram_access_arbiter_if #(parameter int N_REQ = 3) ();
    import sram_arb_pkg::*;
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             req_we_n;
    logic [N_REQ*SRAM_ADDR_W-1:0] req_address;
    logic [N_REQ*SRAM_DATA_W-1:0] req_write_data;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rd_valid;
    logic [SRAM_DATA_W-1:0]       rd_data;
    logic [SRAM_ADDR_W-1:0]       SRAM_address;
    logic [SRAM_DATA_W-1:0]       SRAM_write_data;
    logic                         SRAM_we_n;
    logic [SRAM_DATA_W-1:0]       SRAM_read_data;
    modport master (
        output req, req_we_n, req_address, req_write_data, SRAM_read_data,
        input  gnt, rd_valid, rd_data, SRAM_address, SRAM_write_data, SRAM_we_n
    );
    modport slave (
        input  req, req_we_n, req_address, req_write_data, SRAM_read_data,
        output gnt, rd_valid, rd_data, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first request at or after i_ptr wins.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);
    logic [PW-1:0] w_j;
    // Scan from farthest to nearest so the nearest hit is the one left standing
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin burst-locked sharing of one SRAM_Controller port with read-return routing.
// Optional SRAM_ARB_STATS_EN adds grant_count, a per-requester saturating count of accepted accesses.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 64,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic Clock_50,
    input  logic Reset,
    sram_access_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] grant_count
`endif
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt, w_pick;
    logic [PW-1:0]    r_rr, w_rr_nxt, r_owner, w_owner_nxt, w_pick_idx, w_owner_inc;
    logic [BW-1:0]    r_burst, w_burst_nxt;
    logic             w_acc, w_others, w_last;

    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [SRAM_DATA_W-1:0] r_wdata, r_rd_data;
    logic                   r_we_n;
    logic [READ_LAT:0]      r_pv;
    logic [PW-1:0]          r_pid [READ_LAT+1];

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_rr),
        .o_gnt (w_pick),
        .o_idx (w_pick_idx)
    );

    // gnt is only non-zero in S_ARB_GRANT, so a dropped owner req never counts as an access
    assign w_acc       = |(bus.req & r_gnt);
    assign w_others    = |(bus.req & ~r_gnt);
    assign w_last      = r_burst == BW'(MAX_BURST - 1);
    assign w_owner_inc = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        case (r_state)
            S_ARB_IDLE: if (|bus.req) begin
                w_gnt_nxt   = w_pick;
                w_owner_nxt = w_pick_idx;
                w_burst_nxt = '0;
                w_state_nxt = S_ARB_GRANT;
            end
            S_ARB_GRANT: if (!w_acc || (w_last && w_others)) begin
                w_gnt_nxt   = '0;
                w_rr_nxt    = w_owner_inc;
                w_state_nxt = S_ARB_SWITCH;
            end else begin
                w_burst_nxt = w_last ? '0 : r_burst + 1'b1;
            end
            S_ARB_SWITCH: w_state_nxt = S_ARB_IDLE;
            default:      w_state_nxt = S_ARB_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_state <= S_ARB_IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_owner <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we_n    <= 1'b1;
            r_rd_data <= '0;
            r_pv      <= '0;
            for (int k = 0; k <= READ_LAT; k++) r_pid[k] <= '0;
        end else begin
            r_we_n <= 1'b1;
            if (w_acc) begin
                r_addr  <= bus.req_address[int'(r_owner)*SRAM_ADDR_W +: SRAM_ADDR_W];
                r_wdata <= bus.req_write_data[int'(r_owner)*SRAM_DATA_W +: SRAM_DATA_W];
                r_we_n  <= bus.req_we_n[r_owner];
            end
            r_pv     <= {r_pv[READ_LAT-1:0], w_acc & bus.req_we_n[r_owner]};
            r_pid[0] <= r_owner;
            for (int k = 1; k <= READ_LAT; k++) r_pid[k] <= r_pid[k-1];
            if (r_pv[READ_LAT-1]) r_rd_data <= bus.SRAM_read_data;
        end
    end

    always_comb begin
        bus.rd_valid = '0;
        bus.rd_valid[r_pid[READ_LAT]] = r_pv[READ_LAT];
    end

    assign bus.gnt             = r_gnt;
    assign bus.rd_data         = r_rd_data;
    assign bus.SRAM_address    = r_addr;
    assign bus.SRAM_write_data = r_wdata;
    assign bus.SRAM_we_n       = r_we_n;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_gcnt [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        always_ff @(posedge Clock_50 or posedge Reset) begin
            if (Reset) r_gcnt[g] <= '0;
            else if (bus.req[g] && r_gnt[g] && r_gcnt[g] != 16'hFFFF) r_gcnt[g] <= r_gcnt[g] + 1'b1;
        end
        assign grant_count[16*g +: 16] = r_gcnt[g];
    end
`endif
endmodule
